// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the score digit generator slice.
//   SCORE_W    : width of the binary score register
//   PTS_W      : width of the add_points request field
//   NUM_DIGITS : number of BCD digits shown on screen
//   BCD_W      : total width of the packed BCD value
//   MAX_SCORE  : saturation ceiling, must fit in NUM_DIGITS BCD digits
// ---------------------------------------------------------------------------
package score_pkg;

  localparam int SCORE_W    = 20;
  localparam int PTS_W      = 10;
  localparam int NUM_DIGITS = 6;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int MAX_SCORE  = 999999;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/score_digit_generator_if.sv
// ---------------------------------------------------------------------------
// score_digit_generator_if
// Request/response bundle between the game logic and the score digit
// generator.
//   master : game side, drives add/clear/frame requests, reads digits
//   slave  : generator side
// ---------------------------------------------------------------------------
interface score_digit_generator_if
  import score_pkg::*;
#(
  parameter int SCORE_W_P = SCORE_W,
  parameter int PTS_W_P   = PTS_W
) ();

  logic                 add_valid;
  logic [PTS_W_P-1:0]   add_points;
  logic                 clear_score;
  logic                 startOfFrame;
  bcd_t                 digit1;
  bcd_t                 digit2;
  bcd_t                 digit3;
  bcd_t                 digit4;
  bcd_t                 digit5;
  bcd_t                 digit6;
  logic [SCORE_W_P-1:0] score;
  logic                 saturated;
  logic                 conv_busy;

  modport master (
    output add_valid, add_points, clear_score, startOfFrame,
    input  digit1, digit2, digit3, digit4, digit5, digit6,
    input  score, saturated, conv_busy
  );

  modport slave (
    input  add_valid, add_points, clear_score, startOfFrame,
    output digit1, digit2, digit3, digit4, digit5, digit6,
    output score, saturated, conv_busy
  );

endinterface

// File: rtl/bcd_dabble_step.sv
// ---------------------------------------------------------------------------
// bcd_dabble_step
// One double-dabble iteration: every nibble >= 5 gets +3, then the whole
// BCD value shifts left by one with i_bit entering at the bottom.
//   i_bcd : current packed BCD accumulator
//   i_bit : next binary bit (MSB first)
//   o_bcd : corrected and shifted accumulator
// ---------------------------------------------------------------------------
module bcd_dabble_step
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  input  logic             i_bit,
  output logic [BCD_W-1:0] o_bcd
);

  logic [BCD_W-1:0] w_adj;

  // per-nibble +3 correction ahead of the shift
  always_comb begin
    w_adj = i_bcd;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (i_bcd[4*n +: 4] >= 4'd5) begin
        w_adj[4*n +: 4] = i_bcd[4*n +: 4] + 4'd3;
      end else begin
        w_adj[4*n +: 4] = i_bcd[4*n +: 4];
      end
    end
  end

  assign o_bcd = {w_adj[BCD_W-2:0], i_bit};

endmodule

// File: rtl/score_digit_generator.sv
// ---------------------------------------------------------------------------
// score_digit_generator
// Saturating score accumulator plus a sequential binary-to-BCD converter
// feeding the on-screen digit renderer.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : slave side of score_digit_generator_if
//            (add_valid/add_points, clear_score, startOfFrame in;
//             digit1..digit6, score, saturated, conv_busy out)
// FRAME_SYNC=1 holds a finished conversion until the next startOfFrame so
// the digits never change mid-frame; FRAME_SYNC=0 shows it immediately.
// ---------------------------------------------------------------------------
module score_digit_generator
  import score_pkg::*;
#(
  parameter bit FRAME_SYNC = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetN,
  score_digit_generator_if.slave   bus
);

  localparam int              CNT_W    = $clog2(SCORE_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCORE_W - 1);
  localparam logic [SCORE_W:0] MAX_EXT  = (SCORE_W + 1)'(MAX_SCORE);

  conv_state_t        r_state;
  conv_state_t        w_next_state;
  logic [SCORE_W-1:0] r_score;
  logic               r_saturated;
  logic               r_dirty;
  logic               r_busy;
  logic [SCORE_W-1:0] r_snap;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_result;
  logic               r_pending;
  logic [BCD_W-1:0]   r_digits;
  logic [SCORE_W:0]   w_sum;
  logic [BCD_W-1:0]   w_step;
  logic               w_score_event;

  // one extra bit so an add can never wrap before the ceiling compare
  assign w_sum         = {1'b0, r_score} + {{(SCORE_W + 1 - PTS_W){1'b0}}, bus.add_points};
  assign w_score_event = bus.clear_score | bus.add_valid;

  bcd_dabble_step u_step (
    .i_bcd (r_bcd),
    .i_bit (r_snap[SCORE_W-1]),
    .o_bcd (w_step)
  );

  // score accumulator with sticky saturation; clear overrides add
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_score     <= {SCORE_W{1'b0}};
      r_saturated <= 1'b0;
    end else if (bus.clear_score) begin
      r_score     <= {SCORE_W{1'b0}};
      r_saturated <= 1'b0;
    end else if (bus.add_valid) begin
      if (w_sum > MAX_EXT) begin
        r_score     <= MAX_EXT[SCORE_W-1:0];
        r_saturated <= 1'b1;
      end else begin
        r_score     <= w_sum[SCORE_W-1:0];
      end
    end
  end

  // dirty: a score change not yet captured by a conversion; a change on the
  // capture edge wins so the newer value gets its own conversion
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_dirty <= 1'b0;
    end else if (w_score_event) begin
      r_dirty <= 1'b1;
    end else if (r_state == IDLE) begin
      r_dirty <= 1'b0;
    end
  end

  // conversion state register and registered busy flag
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != IDLE);
    end
  end

  // conversion next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_dirty) begin
          w_next_state = CONV;
        end else begin
          w_next_state = IDLE;
        end
      end
      CONV: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = DONE;
        end else begin
          w_next_state = CONV;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // double-dabble datapath: snapshot on start, one iteration per CONV edge
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_snap <= {SCORE_W{1'b0}};
      r_bcd  <= {BCD_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
    end else if ((r_state == IDLE) && r_dirty) begin
      r_snap <= r_score;
      r_bcd  <= {BCD_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
    end else if (r_state == CONV) begin
      r_bcd  <= w_step;
      r_snap <= {r_snap[SCORE_W-2:0], 1'b0};
      r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // digit presentation; in frame-sync mode only the newest result is kept
  // and a DONE coinciding with startOfFrame bypasses the holding register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_digits  <= {BCD_W{1'b0}};
      r_result  <= {BCD_W{1'b0}};
      r_pending <= 1'b0;
    end else if (!FRAME_SYNC) begin
      if (r_state == DONE) begin
        r_digits <= r_bcd;
      end
    end else if ((r_state == DONE) && bus.startOfFrame) begin
      r_digits  <= r_bcd;
      r_pending <= 1'b0;
    end else if (r_state == DONE) begin
      r_result  <= r_bcd;
      r_pending <= 1'b1;
    end else if (bus.startOfFrame && r_pending) begin
      r_digits  <= r_result;
      r_pending <= 1'b0;
    end
  end

  assign bus.digit1    = r_digits[23:20];
  assign bus.digit2    = r_digits[19:16];
  assign bus.digit3    = r_digits[15:12];
  assign bus.digit4    = r_digits[11:8];
  assign bus.digit5    = r_digits[7:4];
  assign bus.digit6    = r_digits[3:0];
  assign bus.score     = r_score;
  assign bus.saturated = r_saturated;
  assign bus.conv_busy = r_busy;

endmodule

// File: tb/tb_score_digit_generator.sv
// ---------------------------------------------------------------------------
// tb_score_digit_generator
// Directed bench: u_dut0 runs with FRAME_SYNC=0, u_dut1 with FRAME_SYNC=1.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_score_digit_generator;
  import score_pkg::*;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  score_digit_generator_if if0 ();
  score_digit_generator_if if1 ();

  score_digit_generator #(.FRAME_SYNC(1'b0)) u_dut0 (
    .clk    (clk),
    .resetN (resetN),
    .bus    (if0.slave)
  );

  score_digit_generator #(.FRAME_SYNC(1'b1)) u_dut1 (
    .clk    (clk),
    .resetN (resetN),
    .bus    (if1.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] digits0();
    return {8'h00, if0.digit1, if0.digit2, if0.digit3, if0.digit4, if0.digit5, if0.digit6};
  endfunction

  function automatic logic [31:0] digits1();
    return {8'h00, if1.digit1, if1.digit2, if1.digit3, if1.digit4, if1.digit5, if1.digit6};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // one-cycle request to u_dut0; returns just after the sampling edge
  task automatic pulse0(input logic clr, input logic add, input logic [9:0] pts);
    if0.clear_score = clr;
    if0.add_valid   = add;
    if0.add_points  = pts;
    @(negedge clk);
    if0.clear_score = 1'b0;
    if0.add_valid   = 1'b0;
    if0.add_points  = 10'd0;
  endtask

  task automatic pulse1(input logic [9:0] pts);
    if1.add_valid  = 1'b1;
    if1.add_points = pts;
    @(negedge clk);
    if1.add_valid  = 1'b0;
    if1.add_points = 10'd0;
  endtask

  task automatic sof1();
    if1.startOfFrame = 1'b1;
    @(negedge clk);
    if1.startOfFrame = 1'b0;
  endtask

  initial begin
    if0.add_valid = 1'b0; if0.add_points = 10'd0; if0.clear_score = 1'b0; if0.startOfFrame = 1'b0;
    if1.add_valid = 1'b0; if1.add_points = 10'd0; if1.clear_score = 1'b0; if1.startOfFrame = 1'b0;

    // reset
    idle(3);
    resetN = 1'b1;
    idle(2);
    check_val("rst_digits0", digits0(), 32'h0);
    check_val("rst_score0", 32'(if0.score), 32'd0);
    check_val("rst_busy0", 32'(if0.conv_busy), 32'd0);
    check_val("rst_sat0", 32'(if0.saturated), 32'd0);
    check_val("rst_digits1", digits1(), 32'h0);

    // basic conversion and latency
    pulse0(1'b0, 1'b1, 10'd123);
    check_val("add123_score", 32'(if0.score), 32'd123);
    check_val("add123_busy_k", 32'(if0.conv_busy), 32'd0);
    idle(1);
    check_val("add123_busy_k1", 32'(if0.conv_busy), 32'd1);
    idle(20);
    check_val("add123_dig_k21", digits0(), 32'h0);
    check_val("add123_busy_k21", 32'(if0.conv_busy), 32'd1);
    idle(1);
    check_val("add123_dig_k22", digits0(), 32'h000123);
    check_val("add123_busy_k22", 32'(if0.conv_busy), 32'd0);

    // saturation
    pulse0(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < 999; i++) pulse0(1'b0, 1'b1, 10'd1000);
    check_val("build_999000", 32'(if0.score), 32'd999000);
    pulse0(1'b0, 1'b1, 10'd900);
    check_val("build_999900", 32'(if0.score), 32'd999900);
    check_val("sat_before", 32'(if0.saturated), 32'd0);
    pulse0(1'b0, 1'b1, 10'd250);
    check_val("sat_score", 32'(if0.score), 32'd999999);
    check_val("sat_flag", 32'(if0.saturated), 32'd1);
    idle(60);
    check_val("sat_digits", digits0(), 32'h999999);
    pulse0(1'b1, 1'b0, 10'd0);
    check_val("clr_score", 32'(if0.score), 32'd0);
    check_val("clr_sat", 32'(if0.saturated), 32'd0);
    idle(60);
    check_val("clr_digits", digits0(), 32'h0);

    // zero-point add still starts a conversion
    pulse0(1'b0, 1'b1, 10'd0);
    idle(1);
    check_val("add0_busy", 32'(if0.conv_busy), 32'd1);
    idle(60);

    // simultaneous clear and add
    pulse0(1'b0, 1'b1, 10'd500);
    idle(60);
    check_val("s500_digits", digits0(), 32'h000500);
    pulse0(1'b1, 1'b1, 10'd7);
    check_val("clradd_score", 32'(if0.score), 32'd0);
    idle(60);
    check_val("clradd_digits", digits0(), 32'h0);

    // add during conversion
    pulse0(1'b0, 1'b1, 10'd5);
    idle(5);
    pulse0(1'b0, 1'b1, 10'd10);
    check_val("mid_busy", 32'(if0.conv_busy), 32'd1);
    check_val("mid_score", 32'(if0.score), 32'd15);
    idle(16);
    check_val("mid_first_done", digits0(), 32'h000005);
    idle(21);
    check_val("mid_second_hold", digits0(), 32'h000005);
    check_val("mid_second_busy", 32'(if0.conv_busy), 32'd1);
    idle(1);
    check_val("mid_second_done", digits0(), 32'h000015);
    check_val("mid_second_idle", 32'(if0.conv_busy), 32'd0);

    // frame sync: held until startOfFrame
    pulse1(10'd42);
    idle(40);
    check_val("fs_hold", digits1(), 32'h0);
    check_val("fs_idle", 32'(if1.conv_busy), 32'd0);
    sof1();
    check_val("fs_show42", digits1(), 32'h000042);

    // DONE on the same edge as startOfFrame
    pulse1(10'd7);
    idle(21);
    sof1();
    check_val("fs_coincide", digits1(), 32'h000049);
    idle(5);
    sof1();
    check_val("fs_no_stale", digits1(), 32'h000049);

    // newest result wins
    pulse1(10'd1);
    idle(30);
    pulse1(10'd1);
    idle(30);
    check_val("fs_ovr_hold", digits1(), 32'h000049);
    sof1();
    check_val("fs_ovr_show", digits1(), 32'h000051);

    // reset mid-conversion
    pulse0(1'b0, 1'b1, 10'd3);
    idle(5);
    check_val("rstmid_busy_pre", 32'(if0.conv_busy), 32'd1);
    resetN = 1'b0;
    #1;
    check_val("rstmid_busy", 32'(if0.conv_busy), 32'd0);
    check_val("rstmid_score", 32'(if0.score), 32'd0);
    check_val("rstmid_digits", digits0(), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    idle(30);
    check_val("rstmid_after_dig", digits0(), 32'h0);
    check_val("rstmid_after_busy", 32'(if0.conv_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
